vdma_rd_burst_master: RTL and testbench

- AXI4 read-address/read-data engine sitting directly downstream of the read FIFO status controller.
- Accepts one burst or tail request at a time and issues a single AXI4 INCR read burst at the frame's running address.
- Writes the returned beats into the video read FIFO and returns the `resp`/`done` handshakes to the controller.
- Tracks the remaining beats in the frame and drives `tail_status`/`tail_len` back to the controller; `fsync` restarts the frame.

---
 rtl/vdma_axi_pkg.sv | 12 +
 rtl/vdma_frame_addr_gen.sv | 40 ++++
 rtl/vdma_rd_burst_master.sv | 108 ++++++++++
 tb/tb_vdma_rd_burst_master.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/vdma_axi_pkg.sv
// vdma_axi_pkg: shared AXI constants, FSM encoding and helpers for the VDMA read master
package vdma_axi_pkg;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam int RESP_SLVERR = 1;
    typedef enum logic [1:0] {IDLE, ADDR, DATA, FIN} state_t;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/vdma_frame_addr_gen.sv
// vdma_frame_addr_gen: running frame address and remaining-beat tracker with fsync/wrap reload
module vdma_frame_addr_gen
    import vdma_axi_pkg::*;
#(
    parameter int ASIZE = 32,
    parameter int DSIZE = 128,
    parameter int LSIZE = 9,
    parameter logic [ASIZE-1:0] BASE_ADDR = '0,
    parameter logic [19:0] FRAME_BEATS = 20'd8100,
    parameter int BURST_LEN = 100
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             reload,
    input  logic             advance,
    input  logic [LSIZE-1:0] len,
    output logic [ASIZE-1:0] pointer,
    output logic             tail_status,
    output logic [LSIZE-1:0] tail_len
);
    localparam int BSH = clog2(DSIZE / 8);
    logic [19:0] remaining;
    logic [19:0] len_w;
    assign len_w = 20'(len);
    assign tail_status = remaining < 20'(BURST_LEN);
    assign tail_len = remaining[LSIZE-1:0];
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            pointer <= BASE_ADDR;
            remaining <= FRAME_BEATS;
        end else if (reload || (advance && len_w >= remaining)) begin
            // a burst that consumes the rest of the frame wraps back to the start
            pointer <= BASE_ADDR;
            remaining <= FRAME_BEATS;
        end else if (advance) begin
            pointer <= pointer + (ASIZE'(len) << BSH);
            remaining <= remaining - len_w;
        end
    end
endmodule

// File: rtl/vdma_rd_burst_master.sv
// vdma_rd_burst_master: single-outstanding AXI4 INCR read burst engine feeding the video read FIFO
module vdma_rd_burst_master
    import vdma_axi_pkg::*;
#(
    parameter int ASIZE = 32,
    parameter int DSIZE = 128,
    parameter int LSIZE = 9,
    parameter logic [ASIZE-1:0] BASE_ADDR = '0,
    parameter logic [19:0] FRAME_BEATS = 20'd8100,
    parameter int BURST_LEN = 100,
    parameter logic [3:0] ID = 4'd0
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             fsync,
    input  logic             burst_req,
    input  logic             tail_req,
    input  logic [LSIZE-1:0] req_len,
    output logic             resp,
    output logic             done,
    output logic             tail_status,
    output logic [LSIZE-1:0] tail_len,
    output logic [ASIZE-1:0] araddr,
    output logic [7:0]       arlen,
    output logic [2:0]       arsize,
    output logic [1:0]       arburst,
    output logic [3:0]       arid,
    output logic             arvalid,
    input  logic             arready,
    input  logic [DSIZE-1:0] rdata,
    input  logic [1:0]       rresp,
    input  logic             rlast,
    input  logic             rvalid,
    output logic             rready,
    input  logic             fifo_full,
    output logic             fifo_wr,
    output logic [DSIZE-1:0] fifo_wdata,
    output logic             rd_err
);
    state_t state, state_nx;
    logic [LSIZE-1:0] len_r;
    logic [19:0] cnt;
    logic flush, hs, beat, last_beat, reload;
    logic [ASIZE-1:0] pointer;
    logic unused_rresp;
    assign unused_rresp = rresp[0];
    assign arsize = 3'(clog2(DSIZE / 8));
    assign arburst = BURST_INCR;
    assign arid = ID;
    assign arlen = 8'(len_r - 1'b1);
    assign hs = state == ADDR && arvalid && arready;
    assign rready = state == DATA && !fifo_full;
    assign beat = rvalid && rready;
    assign last_beat = beat && (rlast || cnt == 20'(len_r) - 20'd1);
    // a frame restart seen mid-burst takes effect once the burst has drained
    assign reload = (state == IDLE && fsync) || (state == FIN && (flush || fsync));

    vdma_frame_addr_gen #(
        .ASIZE(ASIZE), .DSIZE(DSIZE), .LSIZE(LSIZE),
        .BASE_ADDR(BASE_ADDR), .FRAME_BEATS(FRAME_BEATS), .BURST_LEN(BURST_LEN)
    ) u_addr (
        .clock(clock), .rst_n(rst_n), .reload(reload), .advance(hs), .len(len_r),
        .pointer(pointer), .tail_status(tail_status), .tail_len(tail_len)
    );

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = !fsync && (burst_req || tail_req) ? ADDR : IDLE;
            ADDR:    state_nx = hs ? DATA : ADDR;
            DATA:    state_nx = last_beat ? FIN : DATA;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            len_r <= '0;
            araddr <= BASE_ADDR;
            arvalid <= 1'b0;
            resp <= 1'b0;
            done <= 1'b0;
            fifo_wr <= 1'b0;
            fifo_wdata <= '0;
            rd_err <= 1'b0;
            flush <= 1'b0;
            cnt <= '0;
        end else begin
            if (state == IDLE && state_nx == ADDR) begin
                len_r <= req_len;
                araddr <= pointer;
            end
            if (beat) fifo_wdata <= rdata;
            arvalid <= state == ADDR && !hs;
            resp <= hs;
            done <= state == FIN && !flush && !fsync;
            fifo_wr <= beat && !flush;
            rd_err <= beat && rresp[RESP_SLVERR];
            flush <= (state == ADDR || state == DATA) && (flush || fsync);
            cnt <= state != DATA || last_beat ? '0 : cnt + 20'(beat);
        end
    end
endmodule

// File: tb/tb_vdma_rd_burst_master.sv
// tb_vdma_rd_burst_master: randomized AXI read-slave bench against a frame-level reference model
module tb_vdma_rd_burst_master;
    localparam int FRAME = 250;
    localparam int BURST = 100;
    localparam int BPB = 16;

    logic clock, rst_n, fsync, burst_req, tail_req, resp, done, tail_status;
    logic [8:0] req_len, tail_len;
    logic [31:0] araddr;
    logic [7:0] arlen;
    logic [2:0] arsize;
    logic [1:0] arburst, rresp;
    logic [3:0] arid;
    logic arvalid, arready, rlast, rvalid, rready, fifo_full, fifo_wr, rd_err;
    logic [127:0] rdata, fifo_wdata;

    int n_cmp = 0, n_bad = 0;
    int n_done = 0, n_rderr = 0, n_resp = 0;
    logic [127:0] got_q[$];
    int m_ptr, m_rem;

    vdma_rd_burst_master #(
        .ASIZE(32), .DSIZE(128), .LSIZE(9), .BASE_ADDR(32'h0),
        .FRAME_BEATS(20'd250), .BURST_LEN(100), .ID(4'd5)
    ) dut (
        .clock(clock), .rst_n(rst_n), .fsync(fsync), .burst_req(burst_req), .tail_req(tail_req),
        .req_len(req_len), .resp(resp), .done(done), .tail_status(tail_status), .tail_len(tail_len),
        .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arid(arid),
        .arvalid(arvalid), .arready(arready), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready), .fifo_full(fifo_full), .fifo_wr(fifo_wr),
        .fifo_wdata(fifo_wdata), .rd_err(rd_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clock) begin
        if (fifo_wr) got_q.push_back(fifo_wdata);
        if (done) n_done++;
        if (rd_err) n_rderr++;
        if (resp) n_resp++;
        if (arvalid && arready)
            check("4k_page", 128'(int'(araddr[11:0]) + (int'(arlen) + 1) * BPB <= 4096), 128'(1));
    end

    task automatic check_tail();
        check("tail_status", 128'(tail_status), 128'(m_rem < BURST));
        check("tail_len", 128'(tail_len), 128'(m_rem % 512));
    endtask

    task automatic burst(input int len, input bit tail, input int ar_wait, input int fsync_beat,
                         input int err_beat, input bit full_tog);
        int n, w0, d0, e0, r0;
        bit flushed, accepted;
        logic [127:0] d;
        logic [127:0] exp_q[$];
        w0 = got_q.size(); d0 = n_done; e0 = n_rderr; r0 = n_resp;
        burst_req = !tail; tail_req = tail; req_len = 9'(len);
        n = 0;
        do begin @(posedge clock); #1; n++; end while (!arvalid && n < 8);
        check("ar_latency", 128'(n), 128'(2));
        check("araddr", 128'(araddr), 128'(m_ptr));
        check("arlen", 128'(arlen), 128'(len - 1));
        for (int i = 0; i < ar_wait; i++) begin
            @(posedge clock); #1;
            check("ar_hold", {arvalid, araddr, arlen}, {1'b1, 32'(m_ptr), 8'(len - 1)});
            check("resp_early", 128'(resp), 128'(0));
        end
        arready = 1'b1;
        @(posedge clock); #1;
        arready = 1'b0; burst_req = 1'b0; tail_req = 1'b0;
        check("resp", 128'(resp), 128'(1));
        check("ar_drop", 128'(arvalid), 128'(0));
        m_ptr += len * BPB;
        m_rem -= len;
        if (m_rem <= 0) begin m_ptr = 0; m_rem = FRAME; end
        flushed = 1'b0;
        for (int b = 0; b < len; b++) begin
            if (b == fsync_beat) begin
                fsync = 1'b1; rvalid = 1'b0;
                @(posedge clock); #1;
                fsync = 1'b0; flushed = 1'b1;
            end
            d = {$urandom, $urandom, $urandom, $urandom};
            rvalid = 1'b1; rdata = d; rlast = b == len - 1;
            rresp = b == err_beat ? 2'b10 : 2'($urandom_range(0, 1));
            n = 0;
            do begin
                fifo_full = full_tog && ($urandom_range(0, 1) == 1);
                #1;
                check("rready", 128'(rready), 128'(!fifo_full));
                accepted = rready;
                @(posedge clock); #1; n++;
            end while (!accepted && n < 50);
            if (!accepted) begin
                check("beat_timeout", 128'(0), 128'(1));
                break;
            end
            if (!flushed) exp_q.push_back(d);
        end
        rvalid = 1'b0; rlast = 1'b0; fifo_full = 1'b0;
        @(posedge clock); #1;
        check("done", 128'(done), 128'(!flushed));
        @(posedge clock); #1;
        if (flushed) begin m_ptr = 0; m_rem = FRAME; end
        check("n_wr", 128'(got_q.size() - w0), 128'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && w0 + i < got_q.size(); i++)
            check("wdata", got_q[w0 + i], exp_q[i]);
        check("n_done", 128'(n_done - d0), 128'(!flushed));
        check("n_rd_err", 128'(n_rderr - e0), 128'(err_beat >= 0 && err_beat < len));
        check("n_resp", 128'(n_resp - r0), 128'(1));
        check_tail();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time budget exceeded");
        $fatal(1);
    end

    initial begin
        int len, lim, fb, eb, n;
        rst_n = 1'b0; fsync = 1'b0; burst_req = 1'b0; tail_req = 1'b0; req_len = '0;
        arready = 1'b0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0; fifo_full = 1'b0;
        m_ptr = 0; m_rem = FRAME;
        #12 rst_n = 1'b1;
        @(posedge clock); #1;
        check("rst_araddr", 128'(araddr), 128'(0));
        check("rst_ctrl", {arvalid, rready, resp, done, fifo_wr, rd_err}, 128'(0));
        check("rst_const", {arsize, arburst, arid}, {3'd4, 2'b01, 4'd5});
        check_tail();
        burst(100, 1'b0, 0, -1, -1, 1'b0);
        burst(100, 1'b0, 0, -1, -1, 1'b1);
        burst(50, 1'b1, 0, -1, 3, 1'b0);
        burst(100, 1'b0, 0, 40, -1, 1'b0);
        burst(100, 1'b0, 10, -1, -1, 1'b0);
        for (int k = 0; k < 10; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                fsync = 1'b1;
                @(posedge clock); #1;
                fsync = 1'b0;
                m_ptr = 0; m_rem = FRAME;
                check_tail();
            end
            lim = m_rem < BURST ? m_rem : BURST;
            len = $urandom_range(1, lim);
            fb = $urandom_range(0, 4) == 0 ? int'($urandom_range(0, len - 1)) : -1;
            eb = $urandom_range(0, 2) == 0 ? int'($urandom_range(0, len - 1)) : -1;
            burst(len, m_rem < BURST, $urandom_range(0, 3), fb, eb, $urandom_range(0, 1) == 1);
        end
        fsync = 1'b1;
        @(posedge clock); #1;
        fsync = 1'b0;
        m_ptr = 0; m_rem = FRAME;
        burst(100, 1'b0, 0, -1, -1, 1'b0);
        burst_req = 1'b1; req_len = 9'd100;
        n = 0;
        do begin @(posedge clock); #1; n++; end while (!arvalid && n < 8);
        check("pre_rst_arvalid", 128'(arvalid), 128'(1));
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_arvalid", 128'(arvalid), 128'(0));
        check("async_rst_araddr", 128'(araddr), 128'(0));
        m_ptr = 0; m_rem = FRAME;
        check_tail();
        burst_req = 1'b0;
        @(posedge clock); #3 rst_n = 1'b1;
        @(posedge clock); #1;
        burst(100, 1'b0, 2, -1, -1, 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
